io_port_ctrl: RTL and testbench

Sequencing controller for the multiplexed I/O port block. It accepts single-byte read/write requests from the CPU over a 4-bit I/O address, covering 16 addressable I/O bytes: 2 physical 8-bit ports × 8 multiplexed channels each. For each request it drives the channel mux select and waits a programmable settle time. It then strobes output data into the external channel latch, or samples the input pins, and acknowledges. It sits between the CPU I/O decode and the pad-level tri-state buffers.

---
 rtl/io_port_ctrl_pkg.sv | 46 ++++
 rtl/io_port_ctrl_if.sv | 23 ++
 rtl/io_port_ctrl_drv.sv | 63 ++++++
 rtl/io_port_ctrl.sv | 149 ++++++++++++++
 tb/tb_io_port_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/io_port_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// io_port_ctrl_pkg
//   Shared definitions for the multiplexed I/O port controller:
//   FSM state encodings, ioaddr field positions, port/channel counts and
//   the decoded-request struct used when a CPU request is accepted.
// ---------------------------------------------------------------------------
package io_port_ctrl_pkg;

   localparam int NUM_PORTS = 2;
   localparam int NUM_CHANS = 8;
   localparam int CHAN_W    = 3;
   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 4;
   localparam int CNT_W     = 4;   // holds SETTLE_CYCLES (1..15)

   // ioaddr fields
   localparam int ADDR_PORT_BIT = 3;
   localparam int ADDR_CHAN_MSB = 2;
   localparam int ADDR_CHAN_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef struct packed {
      logic              we;
      logic              port;
      logic [CHAN_W-1:0] chan;
      logic [DATA_W-1:0] wdata;
   } io_req_t;

   function automatic io_req_t decode_req(input logic              we,
                                          input logic [ADDR_W-1:0] ioaddr,
                                          input logic [DATA_W-1:0] wdata);
      io_req_t r;
      r.we    = we;
      r.port  = ioaddr[ADDR_PORT_BIT];
      r.chan  = ioaddr[ADDR_CHAN_MSB:ADDR_CHAN_LSB];
      r.wdata = wdata;
      return r;
   endfunction

endpackage

// File: rtl/io_port_ctrl_if.sv
// ---------------------------------------------------------------------------
// io_port_ctrl_if
//   CPU-side request/acknowledge bus of the I/O port controller.
//   master : CPU I/O decode (drives req/we/ioaddr/wdata)
//   slave  : io_port_ctrl   (drives rdata/ack/busy)
// ---------------------------------------------------------------------------
interface io_port_ctrl_if;
   import io_port_ctrl_pkg::*;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] ioaddr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              busy;

   modport master (output req, we, ioaddr, wdata,
                   input  rdata, ack, busy);
   modport slave  (input  req, we, ioaddr, wdata,
                   output rdata, ack, busy);

endinterface

// File: rtl/io_port_ctrl_drv.sv
// ---------------------------------------------------------------------------
// io_port_drv
//   Per-port pad driver registers: channel select, output enable, output
//   data and the one-cycle latch strobe.
//   i_load   : accept a request for this port (sel <= chan; on write also
//              oe <= 1 and out <= wdata)
//   i_we     : request direction, qualifies i_load
//   i_chan   : channel to select
//   i_wdata  : write byte
//   i_stb    : pulse the latch strobe next cycle
//   i_oe_clr : release the pad output enable
//   o_sel/o_oe/o_out/o_stb : registered pad-side outputs
// ---------------------------------------------------------------------------
module io_port_drv
   import io_port_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_we,
   input  logic [CHAN_W-1:0] i_chan,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_stb,
   input  logic              i_oe_clr,
   output logic [CHAN_W-1:0] o_sel,
   output logic              o_oe,
   output logic [DATA_W-1:0] o_out,
   output logic              o_stb
);

   logic [CHAN_W-1:0] r_sel;
   logic              r_oe;
   logic [DATA_W-1:0] r_out;
   logic              r_stb;

   // sel and out are only ever loaded, never cleared, so they hold across
   // idle periods and reads (no glitching on the mux between transactions).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel <= '0;
         r_oe  <= 1'b0;
         r_out <= '0;
         r_stb <= 1'b0;
      end else begin
         r_stb <= i_stb;
         if (i_load) begin
            r_sel <= i_chan;
            if (i_we) begin
               r_oe  <= 1'b1;
               r_out <= i_wdata;
            end
         end else if (i_oe_clr) begin
            r_oe <= 1'b0;
         end
      end
   end

   assign o_sel = r_sel;
   assign o_oe  = r_oe;
   assign o_out = r_out;
   assign o_stb = r_stb;

endmodule

// File: rtl/io_port_ctrl.sv
// ---------------------------------------------------------------------------
// io_port_ctrl
//   Sequencer for the 2-port x 8-channel multiplexed I/O block. Accepts a
//   single-byte read/write on io_bus, drives the channel mux select, waits
//   SETTLE_CYCLES, then strobes write data into the channel latch or samples
//   the input pins, and pulses ack.
//   clk, rst         : clock, async active-high reset
//   io_bus (slave)   : req/we/ioaddr/wdata in, rdata/ack/busy out
//   o_portN_sel      : channel mux select
//   o_portN_oe       : pad output enable
//   o_portN_out      : pad output data
//   o_portN_stb      : channel latch write strobe
//   i_portN_in       : pad input data
// ---------------------------------------------------------------------------
module io_port_ctrl
   import io_port_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
)(
   input  logic              clk,
   input  logic              rst,
   io_port_ctrl_if.slave     io_bus,
   output logic [CHAN_W-1:0] o_port0_sel,
   output logic [CHAN_W-1:0] o_port1_sel,
   output logic              o_port0_oe,
   output logic              o_port1_oe,
   output logic [DATA_W-1:0] o_port0_out,
   output logic [DATA_W-1:0] o_port1_out,
   output logic              o_port0_stb,
   output logic              o_port1_stb,
   input  logic [DATA_W-1:0] i_port0_in,
   input  logic [DATA_W-1:0] i_port1_in
);

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

   state_t            r_state, w_nxt;
   logic              r_we;        // latched direction
   logic              r_port;      // latched port
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rdata;
   logic              r_ack;
   logic              r_busy;

   io_req_t           w_new;
   logic              w_accept;
   logic              w_stb_go;
   logic              w_access;

   logic [NUM_PORTS-1:0][CHAN_W-1:0] w_sel;
   logic [NUM_PORTS-1:0]             w_oe;
   logic [NUM_PORTS-1:0][DATA_W-1:0] w_out;
   logic [NUM_PORTS-1:0]             w_stb;

   assign w_new = decode_req(io_bus.we, io_bus.ioaddr, io_bus.wdata);

   // --- FSM ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_nxt;
   end

   always_comb begin
      w_nxt    = r_state;
      w_accept = 1'b0;
      w_stb_go = 1'b0;
      w_access = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.req) begin
               w_accept = 1'b1;
               w_nxt    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (r_cnt == 4'd1) begin
               w_nxt    = ST_ACCESS;
               // strobe register is loaded here so it is high exactly
               // during the ACCESS cycle
               w_stb_go = r_we;
            end
         end
         ST_ACCESS: begin
            w_access = 1'b1;
            w_nxt    = ST_DONE;
         end
         ST_DONE: w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   // --- request latch, settle counter, rdata, status ------------------------
   // Channel and write byte are captured directly into the port driver's
   // sel/out registers at acceptance; only direction and port are kept here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_port  <= 1'b0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we   <= w_new.we;
            r_port <= w_new.port;
            r_cnt  <= SETTLE_LD;
         end else if (r_state == ST_SETUP && r_cnt != 4'd1) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_access && !r_we)
            r_rdata <= r_port ? i_port1_in : i_port0_in;
         r_ack  <= (w_nxt == ST_DONE);
         r_busy <= (w_nxt != ST_IDLE);
      end
   end

   // --- per-port drivers ------------------------------------------------------
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      io_port_drv u_drv (
         .clk      (clk),
         .rst      (rst),
         .i_load   (w_accept && (w_new.port == 1'(g))),
         .i_we     (w_new.we),
         .i_chan   (w_new.chan),
         .i_wdata  (w_new.wdata),
         .i_stb    (w_stb_go && (r_port == 1'(g))),
         .i_oe_clr (w_access && (r_port == 1'(g))),
         .o_sel    (w_sel[g]),
         .o_oe     (w_oe[g]),
         .o_out    (w_out[g]),
         .o_stb    (w_stb[g])
      );
   end

   assign o_port0_sel  = w_sel[0];
   assign o_port1_sel  = w_sel[1];
   assign o_port0_oe   = w_oe[0];
   assign o_port1_oe   = w_oe[1];
   assign o_port0_out  = w_out[0];
   assign o_port1_out  = w_out[1];
   assign o_port0_stb  = w_stb[0];
   assign o_port1_stb  = w_stb[1];

   assign io_bus.rdata = r_rdata;
   assign io_bus.ack   = r_ack;
   assign io_bus.busy  = r_busy;

endmodule

// File: tb/tb_io_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_port_ctrl
//   Self-checking bench for io_port_ctrl. Expected outputs are derived from
//   the transaction timeline (period p after acceptance) and a small model
//   of what each port and rdata should hold between transactions.
// ---------------------------------------------------------------------------
module tb_io_port_ctrl;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] p0_sel, p1_sel;
   logic       p0_oe, p1_oe, p0_stb, p1_stb;
   logic [7:0] p0_out, p1_out, pin0, pin1;

   int n_chk  = 0;
   int n_fail = 0;
   int n_txn  = 0;

   // model of held state between transactions
   logic [1:0][2:0] m_sel;
   logic [1:0][7:0] m_out;
   logic [7:0]      m_rdata;

   always #5 clk = ~clk;

   io_port_ctrl_if bus();

   io_port_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk         (clk),
      .rst         (rst),
      .io_bus      (bus),
      .o_port0_sel (p0_sel),
      .o_port1_sel (p1_sel),
      .o_port0_oe  (p0_oe),
      .o_port1_oe  (p1_oe),
      .o_port0_out (p0_out),
      .o_port1_out (p1_out),
      .o_port0_stb (p0_stb),
      .o_port1_stb (p1_stb),
      .i_port0_in  (pin0),
      .i_port1_in  (pin1)
   );

   initial begin
      if (S < 1 || S > 15) begin
         $display("FAIL settle_range: SETTLE_CYCLES=%0d outside 1..15", S);
         $fatal(1);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string ph,
                             input logic [1:0][2:0] esel, input logic [1:0] eoe,
                             input logic [1:0][7:0] eout, input logic [1:0] estb,
                             input logic [7:0] erd, input logic eack, input logic ebusy);
      chk($sformatf("%s p0_sel", ph), 32'(p0_sel), 32'(esel[0]));
      chk($sformatf("%s p1_sel", ph), 32'(p1_sel), 32'(esel[1]));
      chk($sformatf("%s p0_oe",  ph), 32'(p0_oe),  32'(eoe[0]));
      chk($sformatf("%s p1_oe",  ph), 32'(p1_oe),  32'(eoe[1]));
      chk($sformatf("%s p0_out", ph), 32'(p0_out), 32'(eout[0]));
      chk($sformatf("%s p1_out", ph), 32'(p1_out), 32'(eout[1]));
      chk($sformatf("%s p0_stb", ph), 32'(p0_stb), 32'(estb[0]));
      chk($sformatf("%s p1_stb", ph), 32'(p1_stb), 32'(estb[1]));
      chk($sformatf("%s rdata",  ph), 32'(bus.rdata), 32'(erd));
      chk($sformatf("%s ack",    ph), 32'(bus.ack),   32'(eack));
      chk($sformatf("%s busy",   ph), 32'(bus.busy),  32'(ebusy));
   endtask

   task automatic model_reset();
      m_sel   = '0;
      m_out   = '0;
      m_rdata = 8'h00;
   endtask

   task automatic check_idle(input string ph);
      check_outs(ph, m_sel, 2'b00, m_out, 2'b00, m_rdata, 1'b0, 1'b0);
   endtask

   task automatic idle_cycles(input int n);
      bus.req = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.we     = 1'($urandom);
         bus.ioaddr = 4'($urandom);
         bus.wdata  = 8'($urandom);
         @(posedge clk); #1;
         check_idle($sformatf("gap%0d", n_txn));
      end
   endtask

   // Called #1 after an edge; that following edge is acceptance (cycle 0).
   // rst_at = period in which reset is asserted (0 = none).
   task automatic txn(input logic w, input logic [3:0] a, input logic [7:0] wd,
                      input logic [7:0] pi0, input logic [7:0] pi1,
                      input int rst_at, input bit perturb);
      logic            pt;
      logic [2:0]      ch;
      logic [1:0][2:0] esel;
      logic [1:0][7:0] eout;
      logic [1:0]      eoe, estb;
      logic [7:0]      erd, pin_sel;
      string           ph;
      pt = a[3];
      ch = a[2:0];
      n_txn++;
      pin0 = pi0;
      pin1 = pi1;
      pin_sel = pt ? pi1 : pi0;
      bus.req = 1'b1; bus.we = w; bus.ioaddr = a; bus.wdata = wd;
      @(posedge clk);
      for (int p = 1; p <= S + 2; p++) begin
         #1;
         ph = $sformatf("t%0d p%0d", n_txn, p);
         esel = m_sel; esel[pt] = ch;
         eout = m_out; if (w) eout[pt] = wd;
         eoe  = '0;    eoe[pt]  = w && (p <= S + 1);
         estb = '0;    estb[pt] = w && (p == S + 1);
         erd  = (!w && p >= S + 2) ? pin_sel : m_rdata;
         check_outs(ph, esel, eoe, eout, estb, erd, p == S + 2, 1'b1);
         if (p == rst_at) begin
            rst = 1'b1;
            #1;
            model_reset();
            check_outs({ph, " rst_async"}, m_sel, 2'b00, m_out, 2'b00, m_rdata, 1'b0, 1'b0);
            bus.req = 1'b0;
            @(posedge clk); #1;
            check_idle({ph, " rst_held"});
            rst = 1'b0;
            @(posedge clk); #1;
            check_idle({ph, " rst_rel"});
            return;
         end
         if (perturb) begin
            bus.we     = 1'($urandom);
            bus.ioaddr = 4'($urandom);
            bus.wdata  = 8'($urandom);
         end
         if (p == S + 2) bus.req = 1'b0;
         @(posedge clk);
      end
      m_sel[pt] = ch;
      if (w) m_out[pt] = wd;
      else   m_rdata   = pin_sel;
      #1;
      check_idle($sformatf("t%0d post", n_txn));
   endtask

   initial begin
      model_reset();
      // reset with random inputs
      rst = 1'b1;
      bus.req = 1'($urandom); bus.we = 1'($urandom);
      bus.ioaddr = 4'($urandom); bus.wdata = 8'($urandom);
      pin0 = 8'($urandom); pin1 = 8'($urandom);
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      bus.req = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle("after_reset");

      // directed write / read
      txn(1'b1, 4'h5, 8'hA5, 8'h00, 8'h00, 0, 1'b0);
      txn(1'b0, 4'hB, 8'h00, 8'h00, 8'h3C, 0, 1'b0);
      idle_cycles(2);
      // back-to-back: second request raised in the IDLE cycle after ack
      txn(1'b1, 4'h2, 8'h11, 8'h00, 8'h00, 0, 1'b0);
      txn(1'b0, 4'hA, 8'h00, 8'h77, 8'h96, 0, 1'b0);
      // ignored mid-transaction input changes
      txn(1'b1, 4'h1, 8'h5A, 8'h00, 8'h00, 0, 1'b1);
      // reset during SETUP, then during the write strobe cycle
      txn(1'b1, 4'hC, 8'hE7, 8'h00, 8'h00, 1, 1'b0);
      txn(1'b1, 4'h6, 8'hC3, 8'h00, 8'h00, S + 1, 1'b0);
      txn(1'b0, 4'h9, 8'h00, 8'h12, 8'h34, 0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         idle_cycles(int'($urandom_range(0, 2)));
         txn(1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, S + 2)) : 0,
             1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
